// File: rtl/ddr_ctrl_pkg.sv
// ddr_ctrl_pkg
// Shared definitions for the queued DDR controller: DDR command encodings,
// controller FSM state encodings, the phase-timer width and a helper that
// converts a phase length in cycles into the timer preload value.
package ddr_ctrl_pkg;

    // DDR command bus encodings driven on ddr_cmd
    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } ddr_cmd_e;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_ACT      = 3'd2,
        ST_ACCESS   = 3'd3,
        ST_CAS_WAIT = 3'd4
    } ctrl_state_e;

    // Width of the down-counter that times PRE / ACT / CAS_WAIT phases
    localparam int TIMER_W = 8;

    // The timer counts down to zero, so a phase of N cycles preloads N-1
    function automatic logic [TIMER_W-1:0] timer_load(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ddr_cmd_fifo.sv
// ddr_cmd_fifo
// In-order command queue. Pointers carry one extra wrap bit so that full and
// empty are told apart without a separate occupancy counter.
// Ports:
//   clk, reset_n   clock, async active-low reset (queue empty)
//   push/push_data write an entry (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   head_data      oldest entry, valid while !empty
//   full, empty    occupancy flags
module ddr_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against the current occupancy
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Same index with differing wrap bits means the writer lapped the reader
    assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign head_data = mem_r[rd_ptr_r[PW-1:0]];

    // Pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

    // Entry storage; contents are meaningless while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/queued_ddr_ctrl.sv
// queued_ddr_ctrl
// Queued single-bank DDR controller with an open-page policy and an internal
// behavioural memory model indexed by addr[MEM_AW-1:0].
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req_valid/req_ready     request handshake (req_ready = queue not full)
//   req_addr/req_we/req_wdata  request payload
//   rsp_valid/rsp_is_wr/rsp_rdata  one-cycle in-order completion pulse
//   ddr_cmd/ddr_addr/ddr_data/ddr_we_n  DDR command interface
//   busy                    FSM not IDLE or queue non-empty
module queued_ddr_ctrl
    import ddr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_BITS   = 14,
    parameter int MEM_AW     = 8,
    parameter int T_RP       = 2,
    parameter int T_RCD      = 2,
    parameter int T_CL       = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_is_wr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [2:0]            ddr_cmd,
    output logic [ADDR_WIDTH-1:0] ddr_addr,
    inout  wire  [DATA_WIDTH-1:0] ddr_data,
    output logic                  ddr_we_n,
    output logic                  busy
);

    localparam int ENTRY_W   = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int MEM_WORDS = 1 << MEM_AW;

    // Queue interface
    logic                  push_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [ENTRY_W-1:0]    push_entry_s;
    logic [ENTRY_W-1:0]    head_entry_s;
    logic                  head_we_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0] head_wdata_s;
    logic [ROW_BITS-1:0]   head_row_s;
    logic [MEM_AW-1:0]     mem_idx_s;

    // FSM, timer and page state
    ctrl_state_e           state_r;
    ctrl_state_e           state_next_s;
    logic [TIMER_W-1:0]    timer_r;
    logic                  timer_expired_s;
    logic                  row_open_r;
    logic [ROW_BITS-1:0]   open_row_r;

    // Memory model and read capture
    logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rd_capture_r;

    // Registered outputs and their next values
    ddr_cmd_e              ddr_cmd_r;
    ddr_cmd_e              cmd_next_s;
    logic [ADDR_WIDTH-1:0] ddr_addr_r;
    logic [ADDR_WIDTH-1:0] addr_next_s;
    logic                  ddr_we_n_r;
    logic                  we_n_next_s;
    logic                  ddr_drive_r;
    logic                  drive_next_s;
    logic [DATA_WIDTH-1:0] ddr_wdata_r;
    logic [DATA_WIDTH-1:0] wdata_next_s;
    logic                  rsp_valid_r;
    logic                  rsp_valid_next_s;
    logic                  rsp_is_wr_r;
    logic                  rsp_is_wr_next_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_next_s;

    ddr_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Queue push/pop and head-entry field decode; only ACCESS consumes the head
    always_comb begin
        push_s       = req_valid && !fifo_full_s;
        pop_s        = (state_r == ST_ACCESS);
        push_entry_s = {req_we, req_addr, req_wdata};
        {head_we_s, head_addr_s, head_wdata_s} = head_entry_s;
        head_row_s   = head_addr_s[ADDR_WIDTH-1 -: ROW_BITS];
        mem_idx_s    = head_addr_s[MEM_AW-1:0];
    end

    assign timer_expired_s = (timer_r == TIMER_W'(0));

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fifo_empty_s) begin
                    state_next_s = ST_IDLE;
                end else if (row_open_r && (open_row_r == head_row_s)) begin
                    state_next_s = ST_ACCESS;
                end else if (row_open_r) begin
                    state_next_s = ST_PRE;
                end else begin
                    state_next_s = ST_ACT;
                end
            end
            ST_PRE: begin
                if (timer_expired_s) begin
                    state_next_s = ST_ACT;
                end else begin
                    state_next_s = ST_PRE;
                end
            end
            ST_ACT: begin
                if (timer_expired_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_ACT;
                end
            end
            ST_ACCESS: begin
                if (head_we_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CAS_WAIT;
                end
            end
            ST_CAS_WAIT: begin
                if (timer_expired_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CAS_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: commands are issued on entry to a state, so they appear
    // registered in that state's first cycle; completions appear the cycle
    // after ACCESS (writes) or after the last CAS_WAIT cycle (reads)
    always_comb begin
        cmd_next_s       = CMD_NOP;
        addr_next_s      = ddr_addr_r;
        we_n_next_s      = 1'b1;
        drive_next_s     = 1'b0;
        wdata_next_s     = ddr_wdata_r;
        rsp_valid_next_s = 1'b0;
        rsp_is_wr_next_s = 1'b0;
        rsp_rdata_next_s = '0;
        if (state_next_s != state_r) begin
            case (state_next_s)
                ST_PRE: begin
                    cmd_next_s = CMD_PRE;
                end
                ST_ACT: begin
                    cmd_next_s  = CMD_ACT;
                    addr_next_s = ADDR_WIDTH'(head_row_s);
                end
                ST_ACCESS: begin
                    addr_next_s = head_addr_s;
                    if (head_we_s) begin
                        cmd_next_s   = CMD_WR;
                        we_n_next_s  = 1'b0;
                        drive_next_s = 1'b1;
                        wdata_next_s = head_wdata_s;
                    end else begin
                        cmd_next_s = CMD_RD;
                    end
                end
                default: cmd_next_s = CMD_NOP;
            endcase
        end else begin
            cmd_next_s = CMD_NOP;
        end
        if ((state_r == ST_ACCESS) && head_we_s) begin
            rsp_valid_next_s = 1'b1;
            rsp_is_wr_next_s = 1'b1;
        end else if ((state_r == ST_CAS_WAIT) && timer_expired_s) begin
            rsp_valid_next_s = 1'b1;
            rsp_rdata_next_s = rd_capture_r;
        end else begin
            rsp_valid_next_s = 1'b0;
        end
    end

    // Phase timer: preloaded on entry to a timed state, counts down to zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= TIMER_W'(0);
        end else if (state_next_s != state_r) begin
            case (state_next_s)
                ST_PRE:      timer_r <= timer_load(T_RP);
                ST_ACT:      timer_r <= timer_load(T_RCD);
                ST_CAS_WAIT: timer_r <= timer_load(T_CL);
                default:     timer_r <= TIMER_W'(0);
            endcase
        end else if (!timer_expired_s) begin
            timer_r <= timer_r - TIMER_W'(1);
        end
    end

    // Open-page tracking: PRE closes the row, ACT opens the head's row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_open_r <= 1'b0;
            open_row_r <= '0;
        end else if (state_r == ST_PRE) begin
            row_open_r <= 1'b0;
        end else if (state_r == ST_ACT) begin
            row_open_r <= 1'b1;
            open_row_r <= head_row_s;
        end
    end

    // Memory model: writes commit and reads sample at the ACCESS edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_r[i] <= '0;
            end
            rd_capture_r <= '0;
        end else if (state_r == ST_ACCESS) begin
            if (head_we_s) begin
                mem_r[mem_idx_s] <= head_wdata_s;
            end else begin
                rd_capture_r <= mem_r[mem_idx_s];
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ddr_cmd_r   <= CMD_NOP;
            ddr_addr_r  <= '0;
            ddr_we_n_r  <= 1'b1;
            ddr_drive_r <= 1'b0;
            ddr_wdata_r <= '0;
            rsp_valid_r <= 1'b0;
            rsp_is_wr_r <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            ddr_cmd_r   <= cmd_next_s;
            ddr_addr_r  <= addr_next_s;
            ddr_we_n_r  <= we_n_next_s;
            ddr_drive_r <= drive_next_s;
            ddr_wdata_r <= wdata_next_s;
            rsp_valid_r <= rsp_valid_next_s;
            rsp_is_wr_r <= rsp_is_wr_next_s;
            rsp_rdata_r <= rsp_rdata_next_s;
        end
    end

    assign ddr_cmd   = ddr_cmd_r;
    assign ddr_addr  = ddr_addr_r;
    assign ddr_we_n  = ddr_we_n_r;
    assign ddr_data  = ddr_drive_r ? ddr_wdata_r : {DATA_WIDTH{1'bz}};
    assign rsp_valid = rsp_valid_r;
    assign rsp_is_wr = rsp_is_wr_r;
    assign rsp_rdata = rsp_rdata_r;
    assign req_ready = !fifo_full_s;
    assign busy      = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_queued_ddr_ctrl.sv
// tb_queued_ddr_ctrl
// Self-checking bench for queued_ddr_ctrl: a vector table of single
// transactions, hand-written queue-full and reset-in-flight sequences, and a
// randomized phase. A scoreboard predicts every response (data, type, cycle)
// from the page-policy timing rules and a flat memory array.
module tb_queued_ddr_ctrl;

    localparam int T_RP  = 2;
    localparam int T_RCD = 2;
    localparam int T_CL  = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [27:0]  req_addr;
    logic         req_we;
    logic [127:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_is_wr;
    logic [127:0] rsp_rdata;
    logic [2:0]   ddr_cmd;
    logic [27:0]  ddr_addr;
    wire  [127:0] ddr_data;
    logic         ddr_we_n;
    logic         busy;

    queued_ddr_ctrl #(
        .ADDR_WIDTH (28), .DATA_WIDTH (128), .FIFO_DEPTH (4), .ROW_BITS (14),
        .MEM_AW (8), .T_RP (T_RP), .T_RCD (T_RCD), .T_CL (T_CL)
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
        .req_we (req_we), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_is_wr (rsp_is_wr), .rsp_rdata (rsp_rdata),
        .ddr_cmd (ddr_cmd), .ddr_addr (ddr_addr), .ddr_data (ddr_data),
        .ddr_we_n (ddr_we_n), .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pre    = 0;
    int n_act    = 0;

    // Scoreboard state
    typedef struct {
        int           due;
        logic         we;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;
    exp_t         exp_q[$];
    logic [127:0] m_mem [256];
    bit           m_row_open;
    logic [13:0]  m_row;
    int           m_free;

    // Vector table
    typedef struct {
        logic         we;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           lat;
        int           pre;
        int           act;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mkvec(input logic we, input logic [27:0] a, input logic [127:0] d,
                                   input logic [127:0] rd, input int lat, input int pre, input int act);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.rdata = rd; v.lat = lat; v.pre = pre; v.act = act;
        return v;
    endfunction

    // Reference model: a request accepted in cycle n is considered once the
    // controller is free (cycle after acceptance, or its previous completion
    // cycle); then hit/closed/conflict decide when the access happens.
    task automatic model_push(input int n, input logic we, input logic [27:0] a, input logic [127:0] d);
        exp_t        e;
        int          s;
        int          acc;
        logic [13:0] row;
        s   = (n + 1 > m_free) ? n + 1 : m_free;
        row = a[27:14];
        if (!m_row_open)       acc = s + 1 + T_RCD;
        else if (row == m_row) acc = s + 1;
        else                   acc = s + 1 + T_RP + T_RCD;
        e.due   = we ? acc + 1 : acc + 1 + T_CL;
        e.we    = we;
        e.addr  = a;
        e.wdata = d;
        if (we) begin
            m_mem[a[7:0]] = d;
            e.rdata = '0;
        end else begin
            e.rdata = m_mem[a[7:0]];
        end
        m_free     = e.due;
        m_row_open = 1'b1;
        m_row      = row;
        exp_q.push_back(e);
    endtask

    // Monitor: scoreboard responses, check command-bus content, track handshakes
    always @(negedge clk) begin
        if (reset_n) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: actual rsp_valid=1 required no response (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_rsp_cycle", cyc, e.due);
                    check("sb_rsp_is_wr", rsp_is_wr, e.we);
                    check("sb_rsp_rdata", rsp_rdata, e.rdata);
                end
            end
            check("ddr_we_n", ddr_we_n, (ddr_cmd == 3'd3) ? 1'b0 : 1'b1);
            if (ddr_cmd == 3'd4) n_pre++;
            if (ddr_cmd == 3'd1) n_act++;
            if (exp_q.size() != 0) begin
                if (ddr_cmd == 3'd1) check("act_addr", ddr_addr, exp_q[0].addr >> 14);
                if (ddr_cmd == 3'd2) check("rd_addr", ddr_addr, exp_q[0].addr);
                if (ddr_cmd == 3'd3) begin
                    check("wr_addr", ddr_addr, exp_q[0].addr);
                    check("wr_data", ddr_data, exp_q[0].wdata);
                end
            end
            if (req_valid && req_ready) model_push(cyc, req_we, req_addr, req_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a request; returns one step after the handshake with req_valid still high
    task automatic send(input logic we, input logic [27:0] a, input logic [127:0] d, output int hs);
        bit ok;
        ok = 1'b0;
        hs = -1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (req_ready) begin
                hs = cyc;
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL handshake_timeout: actual no req_ready required handshake (addr %0h)", a);
            req_valid = 1'b0;
        end
        step();
    endtask

    task automatic wait_rsp(output int t, output logic isw, output logic [127:0] rd);
        t = -1; isw = 1'b0; rd = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                t = cyc; isw = rsp_is_wr; rd = rsp_rdata;
                break;
            end
        end
        if (t < 0) check("rsp_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_complete", (exp_q.size() == 0) && !busy, 1'b1);
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_row_open = 1'b0;
        m_row = '0;
        m_free = 0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_is_wr", rsp_is_wr, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 128'd0);
        check("rst_ddr_cmd", ddr_cmd, 3'd0);
        check("rst_ddr_addr", ddr_addr, 28'd0);
        check("rst_ddr_we_n", ddr_we_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        step();
        reset_n = 1'b1;
    endtask

    localparam logic [27:0]  ROW1 = 28'h0004000;
    localparam logic [27:0]  ROW2 = 28'h0008000;
    localparam logic [27:0]  ROW3 = 28'h000C000;
    localparam logic [127:0] PA5  = {16{8'hA5}};
    localparam logic [127:0] D1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D2   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    localparam logic [127:0] D3   = 128'h3C3C_3C3C_0000_FFFF_1234_5678_9ABC_DEF0;

    initial begin
        int           hs;
        int           hs1;
        int           t;
        int           gap;
        int           n_rsp;
        bit           found;
        logic         isw;
        logic [127:0] rd;
        logic [27:0]  a;
        logic [127:0] d;

        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

        // we, addr, wdata, rdata, latency, PRE count, ACT count
        vecs[0] = mkvec(1'b1, 28'h10,        PA5, 128'd0, 3 + T_RCD,               0, 1);
        vecs[1] = mkvec(1'b0, 28'h10,        '0,  PA5,    3 + T_CL,                0, 0);
        vecs[2] = mkvec(1'b0, 28'h20,        '0,  128'd0, 3 + T_CL,                0, 0);
        vecs[3] = mkvec(1'b1, ROW1 | 28'h33, D1,  128'd0, 3 + T_RP + T_RCD,        1, 1);
        vecs[4] = mkvec(1'b0, ROW1 | 28'h10, '0,  PA5,    3 + T_CL,                0, 0);
        vecs[5] = mkvec(1'b0, ROW2 | 28'h33, '0,  D1,     3 + T_RP + T_RCD + T_CL, 1, 1);
        vecs[6] = mkvec(1'b1, ROW2 | 28'h10, D2,  128'd0, 3,                       0, 0);
        vecs[7] = mkvec(1'b0, 28'h10,        '0,  D2,     3 + T_RP + T_RCD + T_CL, 1, 1);

        do_reset();

        // Table: one transaction at a time from an idle controller
        for (int i = 0; i < 8; i++) begin
            n_pre = 0;
            n_act = 0;
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, hs);
            req_valid = 1'b0;
            check("busy_after_push", busy, 1'b1);
            wait_rsp(t, isw, rd);
            check("vec_latency", t - hs, vecs[i].lat);
            check("vec_is_wr", isw, vecs[i].we);
            check("vec_rdata", rd, vecs[i].rdata);
            check("vec_idle_at_rsp", busy, 1'b0);
            check("vec_pre_count", n_pre, vecs[i].pre);
            check("vec_act_count", n_act, vecs[i].act);
            step();
        end

        // Queue full: first request conflicts with open row 0, so the queue
        // fills and the fifth request waits for the first pop
        send(1'b1, ROW3 | 28'h1, D1, hs1);
        send(1'b1, ROW3 | 28'h2, D2, hs);
        send(1'b0, ROW3 | 28'h1, '0, hs);
        send(1'b0, ROW3 | 28'h2, '0, hs);
        req_we = 1'b1; req_addr = ROW3 | 28'h1; req_wdata = D3;
        @(negedge clk);
        check("full_req_ready", req_ready, 1'b0);
        send(1'b1, ROW3 | 28'h1, D3, hs);
        check("full_fifth_accept", hs - hs1, 3 + T_RP + T_RCD);
        req_valid = 1'b0;
        drain();

        // Random traffic over three rows and a few indices
        for (int i = 0; i < 60; i++) begin
            a = (28'($urandom_range(0, 2)) << 14) | 28'($urandom_range(0, 7));
            d = {$urandom, $urandom, $urandom, $urandom};
            send(1'($urandom_range(0, 1)), a, d, hs);
            if ($urandom_range(0, 1) == 0) begin
                req_valid = 1'b0;
                gap = $urandom_range(0, 4);
                repeat (gap) step();
            end
        end
        req_valid = 1'b0;
        drain();

        // Reset while a read sits in CAS_WAIT: no response, clean restart
        do_reset();
        send(1'b1, 28'h40, D2, hs);
        req_valid = 1'b0;
        drain();
        send(1'b0, 28'h40, '0, hs);
        req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ddr_cmd == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("cas_rd_issued", found, 1'b1);
        step();
        do_reset();
        n_rsp = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        check("no_rsp_after_reset", n_rsp, 0);
        step();
        send(1'b0, 28'h20, '0, hs);
        req_valid = 1'b0;
        wait_rsp(t, isw, rd);
        check("post_rst_latency", t - hs, 3 + T_RCD + T_CL);
        check("post_rst_is_wr", isw, 1'b0);
        check("post_rst_rdata", rd, 128'd0);
        drain();
        send(1'b0, 28'h40, '0, hs);
        req_valid = 1'b0;
        wait_rsp(t, isw, rd);
        check("post_rst_mem_cleared", rd, 128'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/queued_ddr_ctrl.md
QUEUED_DDR_CTRL -- requirements
Module: queued_ddr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 28: request/DDR address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 128: data word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): command queue entries.
REQ-004 SHALL have parameter ROW_BITS, default 14: row = req_addr[ADDR_WIDTH-1 -: ROW_BITS].
REQ-005 SHALL have parameter MEM_AW, default 8: memory-model index = addr[MEM_AW-1:0].
REQ-006 SHALL have parameters T_RP=2, T_RCD=2, T_CL=3 (each >=1), all in cycles.
REQ-007 SHALL have one clock and an asynchronous active-low reset: clk, reset_n.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 reset_n  in  1  async active-low reset.
REQ-010 req_valid  in  1  request offered.
REQ-011 req_ready  out  1  queue can accept; equals !full.
REQ-012 req_addr  in  ADDR_WIDTH  request address.
REQ-013 req_we  in  1  1=write, 0=read.
REQ-014 req_wdata  in  DATA_WIDTH  write data.
REQ-015 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-016 rsp_is_wr  out  1  completion is a write ack.
REQ-017 rsp_rdata  out  DATA_WIDTH  read data; 0 on write acks.
REQ-018 ddr_cmd  out  3  NOP=0, ACT=1, RD=2, WR=3, PRE=4.
REQ-019 ddr_addr  out  ADDR_WIDTH  row (zero-extended) on ACT, full address on RD/WR, else holds.
REQ-020 ddr_data  inout  DATA_WIDTH  driven with write data only in WR cycle, else Z.
REQ-021 ddr_we_n  out  1  low only in WR cycle.
REQ-022 busy  out  1  FSM not IDLE or queue non-empty.

Function
REQ-023 Handshake SHALL occur on req_valid&&req_ready; entry written at that edge; req_ready SHALL NOT depend on same-cycle pop.
REQ-024 Queue SHALL be in-order; completions SHALL be in request order.
REQ-025 FSM SHALL have states IDLE, PRE, ACT, ACCESS, CAS_WAIT.
REQ-026 IDLE, queue non-empty: row open and match -> ACCESS; open and mismatch -> PRE; none open -> ACT; empty: stay.
REQ-027 PRE SHALL last T_RP cycles, ddr_cmd=PRE in first cycle only, close row, then ACT.
REQ-028 ACT SHALL last T_RCD cycles, ddr_cmd=ACT in first cycle only, record open row, then ACCESS.
REQ-029 ACCESS SHALL last one cycle, issue RD/WR, pop queue head; write updates memory model at that edge -> IDLE; read captures model word -> CAS_WAIT.
REQ-030 CAS_WAIT SHALL last T_CL cycles, then rsp_valid with captured data, return to IDLE.
REQ-031 Write ack SHALL pulse rsp_valid, rsp_is_wr=1 in cycle after ACCESS.
REQ-032 Latency from handshake cycle N: row-hit write rsp at N+3; row-hit read N+3+T_CL; closed row add T_RCD; conflict add T_RP+T_RCD.
REQ-033 Open-page policy: row stays open after access until conflict or reset.
REQ-034 Read after write to same index SHALL return the written data.
REQ-035 Full queue with req_valid SHALL hold req_ready=0; no entry lost or overwritten.
REQ-036 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.

Reset
REQ-037 Reset SHALL: queue empty, row closed, FSM IDLE, memory model zero, rsp_valid=0, rsp_is_wr=0, rsp_rdata=0, ddr_cmd=NOP, ddr_addr=0, ddr_we_n=1, ddr_data=Z, busy=0, req_ready=1.
REQ-038 Reset mid-operation SHALL discard queued and in-flight requests without any response.

Structure
REQ-039 Command encodings and FSM state encodings SHALL live in shared package ddr_ctrl_pkg.
REQ-040 Queue SHALL be sub-module ddr_cmd_fifo (parametrised depth/width, push/pop/full/empty).

Verification
REQ-041 Reset, write 0xA5.. to addr 0x10, read 0x10 -> ACT, WR ack at N+3+T_RCD; read rsp_rdata=0xA5.. with no ACT.
REQ-042 Read unwritten addr 0x20 after reset -> rsp_rdata=0, rsp_is_wr=0.
REQ-043 Access row 1 then row 2 -> PRE, ACT sequence; second response latency includes T_RP+T_RCD.
REQ-044 Push FIFO_DEPTH+1 back-to-back with stalled service -> req_ready=0 after 4 pushes; all 5 complete in order.
REQ-045 Reset asserted during CAS_WAIT -> no rsp_valid; all outputs at reset values; next request completes normally.
